mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the byte-wide unified memory (2048 × 8) of the processor. It shares the single memory port between an instruction-fetch requester (F) and a load/store requester (D). Each 16-bit word access is split into two big-endian byte cycles: high byte at `addr`, low byte at `addr+1`. The arbiter sits between the core's fetch/execute units and the memory instance inside `top`.

## Interface
- `ADDR_W`, 11: byte-address width; memory depth is 2**ADDR_W.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `req_f` / `req_d`  in  1  transaction request from F / D.
- `we_f` / `we_d`  in  1  1 = write word, 0 = read word.
- `addr_f` / `addr_d`  in  ADDR_W  byte address of the high byte; any alignment allowed.
- `wdata_f` / `wdata_d`  in  16  write word; [15:8] goes to `addr`, [7:0] goes to `addr+1`.
- `ack_f` / `ack_d`  out  1  one-cycle completion pulse.
- `rdata_f` / `rdata_d`  out  16  read word; valid when ack is high, held until that port's next read ack.
- `gnt_f` / `gnt_d`  out  1  high while that port owns the memory (states HI, LO, DONE).
- `mem_addr`  out  ADDR_W  memory byte address.
- `mem_wdata`  out  8  memory write byte.
- `mem_we`  out  1  memory write strobe. The memory writes on the rising edge when this is high.
- `mem_rdata`  in  8  memory read byte; combinational from `mem_addr`.

## Operation
- FSM states: IDLE → HI → LO → DONE → IDLE.
- IDLE
  - If any `req_*` is high, pick a winner and latch its we, addr, wdata and grant. Next state is HI.
  - Otherwise stay in IDLE.
- HI
  - `mem_addr` = latched addr.
  - Write: `mem_we`=1, `mem_wdata`=wdata[15:8].
  - Read: capture `mem_rdata` into rdata[15:8] of the granted port.
- LO
  - `mem_addr` = (latched addr + 1) mod 2**ADDR_W. Address 0x7FF wraps to 0x000.
  - Write: `mem_we`=1, `mem_wdata`=wdata[7:0].
  - Read: capture into rdata[7:0].
- DONE
  - Ack of the granted port is high. No arbitration in this state.
  - Requester inputs are ignored here. The requester drops `req` now unless it wants another transaction.
- In IDLE and DONE: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Request inputs must stay stable from assertion until ack. Changes to the ungranted port's inputs have no effect until it is granted.
- A write leaves the port's `rdata` unchanged.
- Arbitration with both requests high: see Configuration.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - `ack_*`=0, `gnt_*`=0, `rdata_*`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Round-robin pointer = F (last-granted).
- `req` sampled high at edge k (FSM in IDLE):
  - HI during cycle k→k+1.
  - LO during cycle k+1→k+2.
  - `ack` high during cycle k+2→k+3.
  - IDLE again at edge k+3.
- Throughput: one word per 4 cycles; back-to-back requests are re-arbitrated in every IDLE cycle.
- Memory writes land at the end of the HI and LO cycles (edges k+1 and k+2).
- Reset asserted mid-transaction:
  - FSM goes to IDLE; no ack is issued.
  - If reset hits after HI but before the LO edge, a write may be partial (high byte written, low byte not). The requester must reissue.
- A request arriving while the FSM is busy waits. No request is lost while it is held high.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, grant the port that was not granted last; the pointer updates at each grant.
  - The first tie after reset goes to D.
  - Neither port waits more than one other transaction.
- `ARB_RR_EN` undefined: fixed priority; D always wins a tie and F may starve. The pointer logic is not compiled.

## Test plan
- Reset: hold `nrst`=0 with random inputs → all outputs 0, no `mem_we`. Release → FSM idle, no ack until a req.
- D write 0xBEEF at 0x010 → memory[0x010]=0xBE, memory[0x011]=0xEF; `ack_d` high exactly 3 edges after the request edge; `rdata_d` unchanged.
- F read at 0x010 after that write → `rdata_f`=0xBEEF with `ack_f`; value held across a following F write.
- Wrap: D write 0x1234 at 0x7FF → memory[0x7FF]=0x12, memory[0x000]=0x34; F read at 0x7FF returns 0x1234.
- Contention: `req_f`, `req_d` held high for 6 transactions.
  - Without `ARB_RR_EN`: six `ack_d`, zero `ack_f`.
  - With `ARB_RR_EN`: acks in order D,F,D,F,D,F.
- Reset during the HI cycle of a D write of 0xA55A to 0x020 (memory pre-filled with 0x00) → memory[0x020]=0xA5 or 0x00 and memory[0x021]=0x00; no ack; the next request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer splitting 16-bit word accesses into big-endian byte cycles.
// Optional macro ARB_RR_EN selects round-robin tie-breaking; default is fixed priority to D.
module mem_arbiter #(
  parameter int ADDR_W = 11
) (
  input  logic              clock,
  input  logic              nrst,
  input  logic              req_f,
  input  logic              req_d,
  input  logic              we_f,
  input  logic              we_d,
  input  logic [ADDR_W-1:0] addr_f,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [15:0]       wdata_f,
  input  logic [15:0]       wdata_d,
  output logic              ack_f,
  output logic              ack_d,
  output logic [15:0]       rdata_f,
  output logic [15:0]       rdata_d,
  output logic              gnt_f,
  output logic              gnt_d,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic              PORT_F   = 1'b0;
  localparam logic              PORT_D   = 1'b1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  state_t              state_r, state_s;
  logic                owner_r, owner_s;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [7:0]          wdata_lo_r;
  logic                take_s, win_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [15:0]         sel_wdata_s;
  logic                gnt_s, ack_f_s, ack_d_s, mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [7:0]          mem_wdata_s;
`ifdef ARB_RR_EN
  logic                last_r;
`endif

  // Winner selection; only acted upon in IDLE
  always_comb begin
    take_s = req_f | req_d;
`ifdef ARB_RR_EN
    // On a tie the port that was not granted last wins
    if (req_f && req_d) begin
      win_s = ~last_r;
    end else begin
      win_s = req_d;
    end
`else
    win_s = req_d;
`endif
    if (win_s == PORT_D) begin
      sel_we_s    = we_d;
      sel_addr_s  = addr_d;
      sel_wdata_s = wdata_d;
    end else begin
      sel_we_s    = we_f;
      sel_addr_s  = addr_f;
      sel_wdata_s = wdata_f;
    end
  end

  // Next state and next values of the registered memory/handshake outputs
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    gnt_s       = 1'b0;
    ack_f_s     = 1'b0;
    ack_d_s     = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = ADDR_ZERO;
    mem_wdata_s = 8'h00;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          state_s     = HI;
          owner_s     = win_s;
          gnt_s       = 1'b1;
          mem_we_s    = sel_we_s;
          mem_addr_s  = sel_addr_s;
          mem_wdata_s = sel_wdata_s[15:8];
        end else begin
          state_s = IDLE;
        end
      end
      HI: begin
        state_s     = LO;
        gnt_s       = 1'b1;
        mem_we_s    = we_r;
        mem_addr_s  = addr_r + ADDR_ONE;
        mem_wdata_s = wdata_lo_r;
      end
      LO: begin
        state_s = DONE;
        gnt_s   = 1'b1;
        ack_f_s = (owner_r == PORT_F);
        ack_d_s = (owner_r == PORT_D);
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state and transaction latch
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_r    <= IDLE;
      owner_r    <= PORT_F;
      we_r       <= 1'b0;
      addr_r     <= ADDR_ZERO;
      wdata_lo_r <= 8'h00;
`ifdef ARB_RR_EN
      last_r     <= PORT_F;
`endif
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      if (state_r == IDLE && take_s) begin
        we_r       <= sel_we_s;
        addr_r     <= sel_addr_s;
        wdata_lo_r <= sel_wdata_s[7:0];
`ifdef ARB_RR_EN
        last_r     <= win_s;
`endif
      end
    end
  end

  // Registered grant, ack and memory port outputs
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      gnt_f     <= 1'b0;
      gnt_d     <= 1'b0;
      ack_f     <= 1'b0;
      ack_d     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_ZERO;
      mem_wdata <= 8'h00;
    end else begin
      gnt_f     <= gnt_s & (owner_s == PORT_F);
      gnt_d     <= gnt_s & (owner_s == PORT_D);
      ack_f     <= ack_f_s;
      ack_d     <= ack_d_s;
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
    end
  end

  // Read byte capture; writes leave the read word untouched
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      rdata_f <= 16'h0000;
      rdata_d <= 16'h0000;
    end else if (!we_r && state_r == HI) begin
      if (owner_r == PORT_D) rdata_d[15:8] <= mem_rdata;
      else                   rdata_f[15:8] <= mem_rdata;
    end else if (!we_r && state_r == LO) begin
      if (owner_r == PORT_D) rdata_d[7:0] <= mem_rdata;
      else                   rdata_f[7:0] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 2048x8 memory.
// Contention expectations follow ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  typedef struct {
    logic        port;   // 0 = F, 1 = D
    logic [15:0] rdata;
  } sb_item_t;

  logic        clock = 1'b0;
  logic        nrst  = 1'b0;
  logic        req_f = 1'b0, req_d = 1'b0, we_f = 1'b0, we_d = 1'b0;
  logic [10:0] addr_f = 11'd0, addr_d = 11'd0;
  logic [15:0] wdata_f = 16'd0, wdata_d = 16'd0;
  logic        ack_f, ack_d, gnt_f, gnt_d, mem_we;
  logic [15:0] rdata_f, rdata_d;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem     [0:2047] = '{default: 8'h00};
  logic [7:0]  ref_mem [0:2047] = '{default: 8'h00};
  logic [15:0] exp_f = 16'h0000, exp_d = 16'h0000;
  sb_item_t    sbq[$];
  int          tests = 0;
  int          fails = 0;

  mem_arbiter #(.ADDR_W(11)) dut (
    .clock(clock), .nrst(nrst),
    .req_f(req_f), .req_d(req_d), .we_f(we_f), .we_d(we_d),
    .addr_f(addr_f), .addr_d(addr_d), .wdata_f(wdata_f), .wdata_d(wdata_d),
    .ack_f(ack_f), .ack_d(ack_d), .rdata_f(rdata_f), .rdata_d(rdata_d),
    .gnt_f(gnt_f), .gnt_d(gnt_d),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Scoreboard: every ack pops the oldest expected completion
  always @(negedge clock) begin : mon
    sb_item_t    it;
    logic [15:0] act;
    if (ack_f || ack_d) begin
      tests++;
      if (ack_f && ack_d) begin
        fails++;
        $display("FAIL sb_dual_ack: ack_f=%0b ack_d=%0b, required one-hot", ack_f, ack_d);
      end else if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_ack: ack_f=%0b ack_d=%0b with empty scoreboard", ack_f, ack_d);
      end else begin
        it  = sbq.pop_front();
        act = it.port ? rdata_d : rdata_f;
        if (ack_d !== it.port || act !== it.rdata) begin
          fails++;
          $display("FAIL sb_ack: port=%0b rdata=%h, required port=%0b rdata=%h",
                   ack_d, act, it.port, it.rdata);
        end
      end
    end
  end

  // Issue one word transaction, record its expectation, wait for the ack
  task automatic txn(input logic port, input logic we, input logic [10:0] a,
                     input logic [15:0] wd, output int lat);
    sb_item_t    it;
    logic [10:0] a1;
    a1 = a + 11'd1;
    @(posedge clock); #1;
    it.port = port;
    if (we) begin
      it.rdata   = port ? exp_d : exp_f;
      ref_mem[a] = wd[15:8];
      ref_mem[a1] = wd[7:0];
    end else begin
      it.rdata = {ref_mem[a], ref_mem[a1]};
      if (port) exp_d = it.rdata;
      else      exp_f = it.rdata;
    end
    sbq.push_back(it);
    if (port) begin req_d = 1'b1; we_d = we; addr_d = a; wdata_d = wd; end
    else      begin req_f = 1'b1; we_f = we; addr_f = a; wdata_f = wd; end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (port ? ack_d : ack_f) begin
        lat = i;
        break;
      end
    end
    req_f = 1'b0;
    req_d = 1'b0;
  endtask

  task automatic test_reset();
    logic [0:0] idle_bad;
    nrst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_f = 1'($urandom); req_d = 1'($urandom);
      we_f = 1'($urandom);  we_d = 1'($urandom);
      addr_f = 11'($urandom); addr_d = 11'($urandom);
      wdata_f = 16'($urandom); wdata_d = 16'($urandom);
      @(posedge clock); #1;
      tests++;
      if ({ack_f, ack_d, gnt_f, gnt_d, mem_we, rdata_f, rdata_d, mem_addr, mem_wdata} !== 56'd0) begin
        fails++;
        $display("FAIL reset_outputs: ack=%b%b gnt=%b%b we=%b rf=%h rd=%h ma=%h mw=%h, required all 0",
                 ack_f, ack_d, gnt_f, gnt_d, mem_we, rdata_f, rdata_d, mem_addr, mem_wdata);
      end
    end
    @(negedge clock);
    req_f = 1'b0; req_d = 1'b0; we_f = 1'b0; we_d = 1'b0;
    nrst = 1'b1;
    idle_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (ack_f || ack_d || gnt_f || gnt_d || mem_we) idle_bad = 1'b1;
    end
    tests++;
    if (idle_bad !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: activity=%b, required 0", idle_bad);
    end
  endtask

  task automatic test_write_d();
    int lat;
    txn(1'b1, 1'b1, 11'h010, 16'hBEEF, lat);
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL write_d_latency: %0d edges, required 3", lat);
    end
    tests++;
    if (mem[11'h010] !== 8'hBE || mem[11'h011] !== 8'hEF) begin
      fails++;
      $display("FAIL write_d_mem: mem[010]=%h mem[011]=%h, required BE EF", mem[11'h010], mem[11'h011]);
    end
  endtask

  task automatic test_read_f();
    int lat;
    txn(1'b0, 1'b0, 11'h010, 16'h0000, lat);
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL read_f_latency: %0d edges, required 3", lat);
    end
    txn(1'b0, 1'b1, 11'h100, 16'h5A3C, lat);
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (rdata_f !== 16'hBEEF) begin
      fails++;
      $display("FAIL read_f_hold: rdata_f=%h, required BEEF", rdata_f);
    end
    tests++;
    if (mem[11'h100] !== 8'h5A || mem[11'h101] !== 8'h3C) begin
      fails++;
      $display("FAIL write_f_mem: mem[100]=%h mem[101]=%h, required 5A 3C", mem[11'h100], mem[11'h101]);
    end
  endtask

  task automatic test_wrap();
    int lat;
    txn(1'b1, 1'b1, 11'h7FF, 16'h1234, lat);
    tests++;
    if (mem[11'h7FF] !== 8'h12 || mem[11'h000] !== 8'h34) begin
      fails++;
      $display("FAIL wrap_mem: mem[7FF]=%h mem[000]=%h, required 12 34", mem[11'h7FF], mem[11'h000]);
    end
    txn(1'b0, 1'b0, 11'h7FF, 16'h0000, lat);
    tests++;
    if (lat !== 3 || rdata_f !== 16'h1234) begin
      fails++;
      $display("FAIL wrap_read: lat=%0d rdata_f=%h, required 3 1234", lat, rdata_f);
    end
  endtask

  task automatic test_contention();
    sb_item_t it;
    int       n;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_RR_EN
      it.port = (i % 2 == 0) ? 1'b1 : 1'b0;
`else
      it.port = 1'b1;
`endif
      it.rdata = it.port ? {ref_mem[11'h7FF], ref_mem[11'h000]} : {ref_mem[11'h010], ref_mem[11'h011]};
      if (it.port) exp_d = it.rdata;
      else         exp_f = it.rdata;
      sbq.push_back(it);
    end
    @(posedge clock); #1;
    req_f = 1'b1; we_f = 1'b0; addr_f = 11'h010;
    req_d = 1'b1; we_d = 1'b0; addr_d = 11'h7FF;
    n = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(posedge clock); #1;
      if (ack_f || ack_d) n++;
    end
    req_f = 1'b0;
    req_d = 1'b0;
    tests++;
    if (n !== 6) begin
      fails++;
      $display("FAIL contention_count: %0d acks, required 6", n);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    @(posedge clock); #1;
    req_d = 1'b1; we_d = 1'b1; addr_d = 11'h020; wdata_d = 16'hA55A;
    @(posedge clock); #1;
    tests++;
    if (gnt_d !== 1'b1 || gnt_f !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 11'h020 || mem_wdata !== 8'hA5) begin
      fails++;
      $display("FAIL hi_cycle: gnt=%b%b we=%b addr=%h wdata=%h, required 01 1 020 A5",
               gnt_f, gnt_d, mem_we, mem_addr, mem_wdata);
    end
    nrst = 1'b0;
    req_d = 1'b0;
    exp_f = 16'h0000;
    exp_d = 16'h0000;
    #1;
    tests++;
    if ({ack_d, gnt_d, mem_we, rdata_d} !== 19'd0) begin
      fails++;
      $display("FAIL async_reset: ack_d=%b gnt_d=%b we=%b rdata_d=%h, required 0",
               ack_d, gnt_d, mem_we, rdata_d);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    nrst = 1'b1;
    tests++;
    if ((mem[11'h020] !== 8'hA5 && mem[11'h020] !== 8'h00) || mem[11'h021] !== 8'h00) begin
      fails++;
      $display("FAIL partial_write: mem[020]=%h mem[021]=%h, required A5|00 and 00", mem[11'h020], mem[11'h021]);
    end
    txn(1'b1, 1'b0, 11'h010, 16'h0000, lat);
    tests++;
    if (lat !== 3 || rdata_d !== 16'hBEEF) begin
      fails++;
      $display("FAIL after_reset_read: lat=%0d rdata_d=%h, required 3 BEEF", lat, rdata_d);
    end
  endtask

  initial begin
    test_reset();
    test_write_d();
    test_read_f();
    test_wrap();
    test_contention();
    test_reset_mid();
    repeat (4) @(posedge clock);
    #1;
    tests++;
    if (sbq.size() !== 0) begin
      fails++;
      $display("FAIL sb_drain: %0d pending, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
